// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg
// Shared types and default sizes for the accumulator read-back streamer.
//   state_t    : sequencer states (IDLE, ISSUE, DRAIN, DONE)
//   DEF_*      : default geometry used by the interface, top level and bench
//   ROW_W      : bits in one returned multi-bank row
//   CNT_W      : row counter width (one extra bit so a full 2^ADDR_WIDTH sweep fits)
// ---------------------------------------------------------------------------
package accum_pkg;

    localparam int DEF_NUM_BANKS  = 4;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int ROW_W = DEF_NUM_BANKS * DEF_DATA_WIDTH;
    localparam int CNT_W = DEF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/accum_rd_streamer_if.sv
// ---------------------------------------------------------------------------
// accum_rd_streamer_if
// Bundles the accumulator read channel and the outgoing row stream.
//   rd_valid/rd_ready/rd_addr/rd_mask : read command (master drives valid/addr/mask)
//   rvalid/rdata                      : fixed-latency read return (no backpressure)
//   m_valid/m_ready/m_data/m_last     : row stream toward the packer
// Modports: master = the streamer, slave = accumulator + downstream consumer.
// ---------------------------------------------------------------------------
interface accum_rd_streamer_if import accum_pkg::*; #(
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                            rd_valid;
    logic                            rd_ready;
    logic [ADDR_WIDTH-1:0]           rd_addr;
    logic [NUM_BANKS-1:0]            rd_mask;
    logic                            rvalid;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rdata;
    logic                            m_valid;
    logic                            m_ready;
    logic [NUM_BANKS*DATA_WIDTH-1:0] m_data;
    logic                            m_last;

    modport master (
        output rd_valid, rd_addr, rd_mask, m_valid, m_data, m_last,
        input  rd_ready, rvalid, rdata, m_ready
    );

    modport slave (
        input  rd_valid, rd_addr, rd_mask, m_valid, m_data, m_last,
        output rd_ready, rvalid, rdata, m_ready
    );

endinterface

// File: rtl/accum_stream_fifo.sv
// ---------------------------------------------------------------------------
// accum_stream_fifo
// Synchronous FIFO holding {last, row} entries for the output stream.
//   clk, rstn      : clock, asynchronous active-low reset (storage included)
//   push/push_data : write an entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head entry (registered storage, no bypass)
//   empty, count   : occupancy status; push and pop may share a cycle
// ---------------------------------------------------------------------------
module accum_stream_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CW'(DEPTH));
    assign do_pop  = pop && (cnt != '0);

    // NOTE: storage sits in the async reset branch so a mid-job abort leaves a
    // clean, all-zero head; this forces flops rather than a RAM macro.
    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/accum_rd_streamer.sv
// ---------------------------------------------------------------------------
// accum_rd_streamer
// Sweeps a contiguous row range of the accumulator, issuing one masked read
// per row, and replays the returned rows as a valid/ready stream with last.
//   clk, rstn       : clock, asynchronous active-low reset
//   start           : job request, accepted only while idle
//   base_addr, len  : first row and row count (len==0 is a no-op job)
//   bank_mask       : banks to read; unmasked slices are returned as zero
//   busy, done      : job in progress / one-cycle end-of-job pulse
//   bus (master)    : read command, fixed-latency return, output stream
// Issue is credit-limited: a read is only launched when the return buffer
// plus the one possible in-flight return fit, because rdata cannot stall.
// ---------------------------------------------------------------------------
module accum_rd_streamer import accum_pkg::*; #(
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    len,
    input  logic [NUM_BANKS-1:0]   bank_mask,
    output logic                   busy,
    output logic                   done,
    accum_rd_streamer_if.master    bus
);

    localparam int ROW_BITS = NUM_BANKS * DATA_WIDTH;
    localparam int CNT_BITS = ADDR_WIDTH + 1;
    localparam int OCC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_BITS-1:0]   len_q;
    logic [NUM_BANKS-1:0]  mask_q;
    logic [CNT_BITS-1:0]   issue_cnt;
    logic                  inflight;
    logic                  tag_last;

    logic                  issue_hs;
    logic                  is_last_issue;
    logic [OCC_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occ;
    logic                  fifo_empty;
    logic                  pop;
    logic [ROW_BITS-1:0]   masked_row;
    logic [ROW_BITS:0]     head;

    // Occupancy ignores a same-cycle pop on purpose: the credit check stays
    // independent of m_ready, so overflow is impossible by construction.
    assign occ           = fifo_count + OCC_W'(inflight);
    assign bus.rd_valid  = (state == ISSUE) && (occ < DEPTH_C);
    assign issue_hs      = bus.rd_valid && bus.rd_ready;
    assign is_last_issue = (issue_cnt == len_q - CNT_BITS'(1));
    assign bus.rd_addr   = base_q + issue_cnt[ADDR_WIDTH-1:0];
    assign bus.rd_mask   = mask_q;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs && is_last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Look ahead through this cycle's pop so done lands on the
                // cycle right after the final beat leaves.
                if (!inflight && (fifo_empty || (fifo_count == OCC_W'(1) && pop))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            mask_q    <= '0;
            issue_cnt <= '0;
            inflight  <= 1'b0;
            tag_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue_hs;
            tag_last <= issue_hs && is_last_issue;
            if (state == IDLE && start && len != '0) begin
                base_q    <= base_addr;
                len_q     <= len;
                mask_q    <= bank_mask;
                issue_cnt <= '0;
            end else if (issue_hs) begin
                issue_cnt <= issue_cnt + CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        masked_row = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            masked_row[i*DATA_WIDTH +: DATA_WIDTH] =
                mask_q[i] ? bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    assign pop = !fifo_empty && bus.m_ready;

    accum_stream_fifo #(
        .WIDTH (ROW_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (bus.rvalid && inflight),
        .push_data ({tag_last, masked_row}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.m_valid = !fifo_empty;
    assign bus.m_last  = head[ROW_BITS];
    assign bus.m_data  = head[ROW_BITS-1:0];

endmodule

// File: tb/tb_accum_rd_streamer.sv
// ---------------------------------------------------------------------------
// tb_accum_rd_streamer
// Directed bench: a fixed-latency accumulator responder returns a known
// pattern per row, a monitor logs commands/beats/done, and a single linear
// sequence compares logs and outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_accum_rd_streamer;
    import accum_pkg::*;

    localparam int NB = DEF_NUM_BANKS;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [NB-1:0] bank_mask = '0;
    logic          busy;
    logic          done;

    accum_rd_streamer_if bus ();

    accum_rd_streamer dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bank_mask (bank_mask),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Row pattern: bank i = {i+1, zeros, row address}.
    function automatic logic [ROW_W-1:0] row_of(input logic [AW-1:0] a);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i*DW +: DW] = {8'(i + 1), 47'd0, a};
        end
        return r;
    endfunction

    // Accumulator model: data one cycle after the command handshake.
    logic ones_mode = 1'b0;
    logic spur_rv   = 1'b0;
    always @(posedge clk) begin
        bus.rvalid <= rstn && ((bus.rd_valid && bus.rd_ready) || spur_rv);
        bus.rdata  <= ones_mode ? '1 : row_of(bus.rd_addr);
    end

    // Monitor: samples mid-cycle; handshakes complete at the following edge.
    logic [AW-1:0]    cmd_addr [$];
    logic [NB-1:0]    cmd_mask [$];
    int               cmd_cyc  [$];
    logic [ROW_W-1:0] beat_data[$];
    logic             beat_last[$];
    int               beat_cyc [$];
    int               done_cnt    = 0;
    int               done_cyc    = 0;
    int               busy_cycles = 0;

    always @(negedge clk) begin
        if (bus.rd_valid && bus.rd_ready) begin
            cmd_addr.push_back(bus.rd_addr);
            cmd_mask.push_back(bus.rd_mask);
            cmd_cyc.push_back(cyc);
        end
        if (bus.m_valid && bus.m_ready) begin
            beat_data.push_back(bus.m_data);
            beat_last.push_back(bus.m_last);
            beat_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cycles++;
    end

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int l, input logic [NB-1:0] m,
                               output int sc);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        len       = (AW+1)'(l);
        bank_mask = m;
        sc        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int c0, b0, d0, z0, sc;
        logic [AW-1:0]    exp2 [4];
        logic [ROW_W-1:0] hi_mask;
        exp2    = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        hi_mask = {{(ROW_W/2){1'b1}}, {(ROW_W/2){1'b0}}};

        bus.rd_ready = 1'b1;
        bus.m_ready  = 1'b1;

        // Reset state
        tick(3);
        check("reset_ctl", {busy, done, bus.rd_valid, bus.m_valid, bus.m_last}, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_rd_mask", bus.rd_mask, 0);
        check("reset_m_data", bus.m_data, 0);
        rstn = 1'b1;
        tick(2);

        // 1: base 0x010, len 8, full mask, no backpressure
        c0 = cmd_addr.size(); b0 = beat_data.size(); d0 = done_cnt; z0 = busy_cycles;
        pulse_start(9'h010, 8, 4'b1111, sc);
        wait_idle("t1_idle", 100);
        check("t1_ncmd", cmd_addr.size() - c0, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_addr%0d", i), cmd_addr[c0+i], AW'(9'h010 + i));
            check($sformatf("t1_data%0d", i), beat_data[b0+i], row_of(AW'(9'h010 + i)));
            check($sformatf("t1_last%0d", i), beat_last[b0+i], (i == 7));
        end
        check("t1_mask", cmd_mask[c0], 4'b1111);
        check("t1_start_lat", cmd_cyc[c0] - sc, 1);
        check("t1_back2back", cmd_cyc[c0+7] - cmd_cyc[c0], 7);
        check("t1_nbeat", beat_data.size() - b0, 8);
        check("t1_beat_lat", beat_cyc[b0] - cmd_cyc[c0], 2);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_done_cyc", done_cyc - sc, 11);
        check("t1_busy_len", busy_cycles - z0, 11);

        // 2: address wrap, with an initial rd_ready stall
        c0 = cmd_addr.size(); b0 = beat_data.size();
        bus.rd_ready = 1'b0;
        pulse_start(9'h1FE, 4, 4'b1111, sc);
        tick(2);
        check("t2_hold_valid", bus.rd_valid, 1);
        check("t2_hold_addr", bus.rd_addr, 9'h1FE);
        bus.rd_ready = 1'b1;
        wait_idle("t2_idle", 100);
        check("t2_ncmd", cmd_addr.size() - c0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), cmd_addr[c0+i], exp2[i]);
            check($sformatf("t2_data%0d", i), beat_data[b0+i], row_of(exp2[i]));
        end
        check("t2_last", beat_last[b0+3], 1);

        // 3: partial mask with all-ones return data
        c0 = cmd_addr.size(); b0 = beat_data.size();
        ones_mode = 1'b1;
        pulse_start(9'h020, 2, 4'b0101, sc);
        wait_idle("t3_idle", 100);
        ones_mode = 1'b0;
        check("t3_rd_mask", cmd_mask[c0], 4'b0101);
        check("t3_nbeat", beat_data.size() - b0, 2);
        check("t3_data0", beat_data[b0],
              256'h0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF);
        check("t3_data1", beat_data[b0+1],
              256'h0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF);

        // 4: stream stalled for 20 cycles, credit limit holds issue at 4
        c0 = cmd_addr.size(); b0 = beat_data.size(); d0 = done_cnt;
        bus.m_ready = 1'b0;
        pulse_start(9'h100, 16, 4'b1111, sc);
        tick(20);
        check("t4_stall_ncmd", cmd_addr.size() - c0, 4);
        check("t4_stall_nbeat", beat_data.size() - b0, 0);
        check("t4_stall_rdv", bus.rd_valid, 0);
        check("t4_stall_mv", bus.m_valid, 1);
        bus.m_ready = 1'b1;
        wait_idle("t4_idle", 200);
        check("t4_ncmd", cmd_addr.size() - c0, 16);
        check("t4_nbeat", beat_data.size() - b0, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_data%0d", i), beat_data[b0+i], row_of(AW'(9'h100 + i)));
            check($sformatf("t4_last%0d", i), beat_last[b0+i], (i == 15));
        end
        check("t4_done_cnt", done_cnt - d0, 1);
        check("t4_done_cyc", done_cyc - beat_cyc[b0+15], 1);

        // 5a: len == 0
        c0 = cmd_addr.size(); b0 = beat_data.size(); d0 = done_cnt; z0 = busy_cycles;
        pulse_start(9'h050, 0, 4'b1111, sc);
        wait_idle("t5a_idle", 20);
        check("t5a_ncmd", cmd_addr.size() - c0, 0);
        check("t5a_done_cnt", done_cnt - d0, 1);
        check("t5a_done_cyc", done_cyc - sc, 1);
        check("t5a_busy_len", busy_cycles - z0, 1);

        // 5b: start while busy is ignored
        c0 = cmd_addr.size(); b0 = beat_data.size(); d0 = done_cnt;
        pulse_start(9'h040, 4, 4'b1111, sc);
        start = 1'b1; base_addr = 9'h100; len = 10'd8;
        tick(1);
        start = 1'b0;
        wait_idle("t5b_idle", 100);
        tick(3);
        check("t5b_busy_after", busy, 0);
        check("t5b_ncmd", cmd_addr.size() - c0, 4);
        check("t5b_addr_last", cmd_addr[c0+3], 9'h043);
        check("t5b_nbeat", beat_data.size() - b0, 4);
        check("t5b_done_cnt", done_cnt - d0, 1);

        // 5c: stray rvalid while idle is dropped
        b0 = beat_data.size();
        spur_rv = 1'b1;
        tick(3);
        spur_rv = 1'b0;
        tick(3);
        check("t5c_nbeat", beat_data.size() - b0, 0);
        check("t5c_m_valid", bus.m_valid, 0);

        // 6: reset in DRAIN with 3 rows buffered, then a fresh job
        b0 = beat_data.size(); d0 = done_cnt;
        bus.m_ready = 1'b0;
        pulse_start(9'h0F0, 3, 4'b1111, sc);
        tick(5);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_mv", bus.m_valid, 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_ctl", {busy, done, bus.rd_valid, bus.m_valid, bus.m_last}, 0);
        check("t6_rst_addr", bus.rd_addr, 0);
        check("t6_rst_mask", bus.rd_mask, 0);
        check("t6_rst_data", bus.m_data, 0);
        tick(2);
        rstn = 1'b1;
        bus.m_ready = 1'b1;
        tick(4);
        check("t6_no_beat", beat_data.size() - b0, 0);
        check("t6_no_done", done_cnt - d0, 0);
        c0 = cmd_addr.size(); b0 = beat_data.size(); d0 = done_cnt;
        pulse_start(9'h080, 3, 4'b1100, sc);
        wait_idle("t6_idle", 100);
        check("t6_ncmd", cmd_addr.size() - c0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_addr%0d", i), cmd_addr[c0+i], AW'(9'h080 + i));
            check($sformatf("t6_data%0d", i), beat_data[b0+i], row_of(AW'(9'h080 + i)) & hi_mask);
            check($sformatf("t6_last%0d", i), beat_last[b0+i], (i == 2));
        end
        check("t6_done_cnt", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/accum_rd_streamer.md
# accum_rd_streamer

Read-back sequencer on the read half of the accumulator command/data channels. On a start pulse it sweeps a contiguous row range, issues one masked read per row, and captures each returned multi-bank row. It emits the rows as a valid/ready stream with a last flag for the downstream packer/writeback stage. Credit-based issue guarantees that no returned row is ever dropped, because the accumulator's rdata has fixed latency and cannot be stalled.

## Interface
- NUM_BANKS, 4, banks per row (one DATA_WIDTH slice each)
- ADDR_WIDTH, 9, row address width
- DATA_WIDTH, 64, bits per bank slice
- FIFO_DEPTH, 4, return buffer entries (power of two, >= 2)

Clock and reset (one clock; reset is asynchronous, active-low):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- base_addr  in  ADDR_WIDTH  first row, sampled with start
- len  in  ADDR_WIDTH+1  row count, sampled with start; 0 = no-op
- bank_mask  in  NUM_BANKS  banks to read, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- rd_valid  out  1  read command valid
- rd_ready  in  1  read command accepted
- rd_addr  out  ADDR_WIDTH  read row address
- rd_mask  out  NUM_BANKS  read bank mask
- rvalid  in  1  read data valid, exactly 1 cycle after rd_valid&&rd_ready
- rdata  in  NUM_BANKS*DATA_WIDTH  returned row, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  NUM_BANKS*DATA_WIDTH  stream row
- m_last  out  1  marks final row of job

## Operation
- FSM states:
  - IDLE: on start with len==0, go to DONE. On start with len!=0, latch base_addr, len and bank_mask, clear the issue counter, and go to ISSUE.
  - ISSUE: rd_valid=1 when occ < FIFO_DEPTH, where occ = fifo_count + inflight. The issue counter increments on rd_valid&&rd_ready. After the handshake for row len-1, go to DRAIN.
  - DRAIN: wait until inflight==0 and the FIFO is empty, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in ISSUE, DRAIN and DONE.
- rd_addr = base + issue_count, modulo 2^ADDR_WIDTH (wraps; no error). rd_mask = latched bank_mask.
- inflight is set on a command handshake and cleared on the next cycle.
- On rvalid && inflight, push {last, masked row} into the FIFO.
  - Slices of unmasked banks are forced to 0.
  - last is 1 for issue index len-1, carried by a one-deep tag register.
- rvalid without inflight is ignored.
- m_valid = FIFO not empty; m_data/m_last come from the FIFO head. Pop on m_valid&&m_ready.
- start while busy is ignored.
- rd_valid may be held high while rd_ready=0; rd_addr and rd_mask stay stable until the handshake.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: busy, done, rd_valid, rd_addr, rd_mask, m_valid, m_last, m_data all 0.
  - FIFO storage is reset.
- Reset mid-job aborts the job immediately. No done pulse; FIFO contents are discarded.
- Latency:
  - start to first rd_valid: 1 cycle.
  - Command handshake (cycle n) to rvalid: cycle n+1.
  - m_valid: cycle n+2 (registered FIFO).
- Throughput: with m_ready and rd_ready held high, one row per cycle, and rd_valid never drops mid-job.
- Credit rule: occupancy does not count a same-cycle pop (conservative). The FIFO can never overflow, including when m_ready is low for an unbounded time.
- len==0: done pulses on the cycle after start; no reads are issued; busy is high for that one cycle only.
- len = 2^ADDR_WIDTH: every row is read exactly once, and the address wraps back to base.
- done asserts the cycle after the pop of the last row.

## Structure
- Package accum_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - localparams ROW_W = NUM_BANKS*DATA_WIDTH and CNT_W = ADDR_WIDTH+1.
- One sub-module, accum_stream_fifo: synchronous FIFO of {last, row} with count output, async active-low reset, and push/pop in the same cycle allowed.
- The top level holds the FSM, issue counter, inflight/tag registers and masking.

## Test plan
- base=0x010, len=8, mask=4'b1111, m_ready=1, rd_ready=1 -> 8 consecutive rd_valid at addrs 0x010..0x017; 8 stream beats equal to memory rows; m_last only on beat 8; done once.
- base=0x1FE, len=4 -> addrs 0x1FE, 0x1FF, 0x000, 0x001 (wrap).
- mask=4'b0101 with rdata all-ones -> m_data slices 1 and 3 are zero; rd_mask=4'b0101.
- len=16, m_ready=0 for 20 cycles, then 1 -> rd_valid stalls once occ reaches 4; no beat lost or duplicated; order preserved; done after beat 16.
- len=0 -> done on the cycle after start; no rd_valid; busy for one cycle. Also: start during busy is ignored.
- rstn asserted mid-DRAIN with 3 rows buffered -> all outputs 0; no done; a fresh job afterwards runs correctly.
